ex_mem_reg: RTL
===============

// Module: ex_mem_reg
// PURPOSE
//  EX/MEM pipeline register. Captures EX-stage results and control each enabled cycle and
//  presents them to the MEM stage. Supports debug-unit stepping (enable), branch-flush
//  bubbles and a sticky halt that drains the pipe: after HLT, no new work enters MEM.
// PARAMETERS
//  NB_DATA  32  width of ALU result and store data
//  NB_PC    32  width of PC and branch target
//  NB_REG   5   register index width
// PORTS
//  i_clock               in   1       rising-edge clock
//  i_reset               in   1       synchronous, active-low reset
//  i_enable              in   1       debug-unit step/run enable; 0 = hold all state
//  i_flush               in   1       branch taken in MEM; insert bubble
//  i_EX_reg_write        in   1       WB write flag
//  i_EX_mem_to_reg       in   1       WB mux select
//  i_EX_mem_read         in   1       load
//  i_EX_mem_write        in   1       store
//  i_EX_signed           in   1       sign-extend loads
//  i_EX_word_en          in   1       word access
//  i_EX_halfword_en      in   1       halfword access
//  i_EX_byte_en          in   1       byte access
//  i_EX_branch           in   1       branch instruction
//  i_EX_zero             in   1       ALU zero flag
//  i_EX_r31_ctrl         in   1       link write to r31
//  i_EX_hlt              in   1       HLT instruction
//  i_EX_branch_addr      in   NB_PC   branch target
//  i_EX_alu_result       in   NB_DATA  ALU result / memory address
//  i_EX_write_data       in   NB_DATA  store data
//  i_EX_selected_reg     in   NB_REG  destination register
//  i_EX_pc               in   NB_PC   PC+4 of instruction
//  o_MEM_*               out  same    registered copy of each i_EX_* field (same names)
//  o_halted              out  1       sticky: HLT has passed through this register
// BEHAVIOUR
//  - All updates on rising i_clock. Priority: reset > hold > halted-bubble > flush > capture.
//  - Reset (i_reset==0, sampled at edge): every o_MEM_* = 0, o_halted = 0. Applies regardless
//    of i_enable and mid-operation; next edge with i_reset==1 resumes normally.
//  - Hold (i_enable==0): all outputs and o_halted keep value; i_flush is ignored.
//  - Capture (i_enable==1, no flush, not halted): every o_MEM_* <= i_EX_*; latency 1 cycle.
//  - Flush (i_enable==1, i_flush==1): control bits (reg_write, mem_to_reg, mem_read,
//    mem_write, branch, zero, r31_ctrl, hlt, word/halfword/byte_en, signed) <= 0;
//    data fields (alu_result, write_data, branch_addr, pc, selected_reg) still captured.
//    An i_EX_hlt arriving with i_flush is discarded (wrong-path) and does not set o_halted.
//  - Halt: on a capture edge with i_EX_hlt==1, o_MEM_hlt <= 1 and o_halted <= 1 on that
//    same edge. While o_halted==1 and i_enable==1, each edge loads a bubble (all control
//    bits 0, o_MEM_hlt 0, data fields 0). o_halted clears only on reset.
//  - Bubble = no reg write, no memory access, no branch: MEM/WB side-effect free.
//  - No arithmetic; fields are passed through bit-exact, no width conversion.
// TESTING
//  1 reset: drive i_reset=0 one edge with all inputs =1 -> all outputs 0, o_halted 0.
//  2 capture: enable=1, alu_result=0x0000_0010, write_data=0xDEAD_BEEF, mem_write=1,
//    word_en=1, selected_reg=5 -> next edge outputs equal inputs exactly.
//  3 hold: enable=0 for 3 cycles while inputs change -> outputs frozen at prior values;
//    enable=1 -> captures current inputs on next edge.
//  4 flush: branch=1, zero=1, reg_write=1, alu_result=0x20, flush=1 -> control outputs 0,
//    o_MEM_alu_result=0x20; flush with enable=0 -> no change.
//  5 halt: capture hlt=1, pc=0x40 -> o_MEM_hlt=1, o_halted=1; next 4 edges with valid
//    reg_write=1 inputs -> all outputs 0, o_halted stays 1; reset -> o_halted 0.
//  6 flushed halt: hlt=1 with flush=1 -> o_MEM_hlt 0, o_halted 0, next capture normal.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline bus: EX-stage fields in, registered MEM-stage fields out.
interface ex_mem_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5
) ();
    logic               i_EX_reg_write;
    logic               i_EX_mem_to_reg;
    logic               i_EX_mem_read;
    logic               i_EX_mem_write;
    logic               i_EX_signed;
    logic               i_EX_word_en;
    logic               i_EX_halfword_en;
    logic               i_EX_byte_en;
    logic               i_EX_branch;
    logic               i_EX_zero;
    logic               i_EX_r31_ctrl;
    logic               i_EX_hlt;
    logic [NB_PC-1:0]   i_EX_branch_addr;
    logic [NB_DATA-1:0] i_EX_alu_result;
    logic [NB_DATA-1:0] i_EX_write_data;
    logic [NB_REG-1:0]  i_EX_selected_reg;
    logic [NB_PC-1:0]   i_EX_pc;

    logic               o_MEM_reg_write;
    logic               o_MEM_mem_to_reg;
    logic               o_MEM_mem_read;
    logic               o_MEM_mem_write;
    logic               o_MEM_signed;
    logic               o_MEM_word_en;
    logic               o_MEM_halfword_en;
    logic               o_MEM_byte_en;
    logic               o_MEM_branch;
    logic               o_MEM_zero;
    logic               o_MEM_r31_ctrl;
    logic               o_MEM_hlt;
    logic [NB_PC-1:0]   o_MEM_branch_addr;
    logic [NB_DATA-1:0] o_MEM_alu_result;
    logic [NB_DATA-1:0] o_MEM_write_data;
    logic [NB_REG-1:0]  o_MEM_selected_reg;
    logic [NB_PC-1:0]   o_MEM_pc;

    // The EX stage drives the i_EX_* fields and observes the MEM side.
    modport master (
        output i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write,
               i_EX_signed, i_EX_word_en, i_EX_halfword_en, i_EX_byte_en,
               i_EX_branch, i_EX_zero, i_EX_r31_ctrl, i_EX_hlt,
               i_EX_branch_addr, i_EX_alu_result, i_EX_write_data,
               i_EX_selected_reg, i_EX_pc,
        input  o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_mem_read, o_MEM_mem_write,
               o_MEM_signed, o_MEM_word_en, o_MEM_halfword_en, o_MEM_byte_en,
               o_MEM_branch, o_MEM_zero, o_MEM_r31_ctrl, o_MEM_hlt,
               o_MEM_branch_addr, o_MEM_alu_result, o_MEM_write_data,
               o_MEM_selected_reg, o_MEM_pc
    );

    modport slave (
        input  i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write,
               i_EX_signed, i_EX_word_en, i_EX_halfword_en, i_EX_byte_en,
               i_EX_branch, i_EX_zero, i_EX_r31_ctrl, i_EX_hlt,
               i_EX_branch_addr, i_EX_alu_result, i_EX_write_data,
               i_EX_selected_reg, i_EX_pc,
        output o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_mem_read, o_MEM_mem_write,
               o_MEM_signed, o_MEM_word_en, o_MEM_halfword_en, o_MEM_byte_en,
               o_MEM_branch, o_MEM_zero, o_MEM_r31_ctrl, o_MEM_hlt,
               o_MEM_branch_addr, o_MEM_alu_result, o_MEM_write_data,
               o_MEM_selected_reg, o_MEM_pc
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with debug enable, flush bubbles and a sticky halt
// that drains the pipe once HLT has passed through.
module ex_mem_reg (
    input  logic     i_clock,
    input  logic     i_reset,
    input  logic     i_enable,
    input  logic     i_flush,
    ex_mem_if.slave  bus,
    output logic     o_halted
);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            bus.o_MEM_reg_write    <= 1'b0;
            bus.o_MEM_mem_to_reg   <= 1'b0;
            bus.o_MEM_mem_read     <= 1'b0;
            bus.o_MEM_mem_write    <= 1'b0;
            bus.o_MEM_signed       <= 1'b0;
            bus.o_MEM_word_en      <= 1'b0;
            bus.o_MEM_halfword_en  <= 1'b0;
            bus.o_MEM_byte_en      <= 1'b0;
            bus.o_MEM_branch       <= 1'b0;
            bus.o_MEM_zero         <= 1'b0;
            bus.o_MEM_r31_ctrl     <= 1'b0;
            bus.o_MEM_hlt          <= 1'b0;
            bus.o_MEM_branch_addr  <= '0;
            bus.o_MEM_alu_result   <= '0;
            bus.o_MEM_write_data   <= '0;
            bus.o_MEM_selected_reg <= '0;
            bus.o_MEM_pc           <= '0;
            o_halted               <= 1'b0;
        end else if (i_enable) begin
            if (o_halted) begin
                // Drained pipe: everything zero so MEM/WB see a side-effect-free bubble.
                bus.o_MEM_reg_write    <= 1'b0;
                bus.o_MEM_mem_to_reg   <= 1'b0;
                bus.o_MEM_mem_read     <= 1'b0;
                bus.o_MEM_mem_write    <= 1'b0;
                bus.o_MEM_signed       <= 1'b0;
                bus.o_MEM_word_en      <= 1'b0;
                bus.o_MEM_halfword_en  <= 1'b0;
                bus.o_MEM_byte_en      <= 1'b0;
                bus.o_MEM_branch       <= 1'b0;
                bus.o_MEM_zero         <= 1'b0;
                bus.o_MEM_r31_ctrl     <= 1'b0;
                bus.o_MEM_hlt          <= 1'b0;
                bus.o_MEM_branch_addr  <= '0;
                bus.o_MEM_alu_result   <= '0;
                bus.o_MEM_write_data   <= '0;
                bus.o_MEM_selected_reg <= '0;
                bus.o_MEM_pc           <= '0;
            end else begin
                // Flush kills control (including a wrong-path HLT) but data still flows.
                bus.o_MEM_reg_write    <= bus.i_EX_reg_write   & ~i_flush;
                bus.o_MEM_mem_to_reg   <= bus.i_EX_mem_to_reg  & ~i_flush;
                bus.o_MEM_mem_read     <= bus.i_EX_mem_read    & ~i_flush;
                bus.o_MEM_mem_write    <= bus.i_EX_mem_write   & ~i_flush;
                bus.o_MEM_signed       <= bus.i_EX_signed      & ~i_flush;
                bus.o_MEM_word_en      <= bus.i_EX_word_en     & ~i_flush;
                bus.o_MEM_halfword_en  <= bus.i_EX_halfword_en & ~i_flush;
                bus.o_MEM_byte_en      <= bus.i_EX_byte_en     & ~i_flush;
                bus.o_MEM_branch       <= bus.i_EX_branch      & ~i_flush;
                bus.o_MEM_zero         <= bus.i_EX_zero        & ~i_flush;
                bus.o_MEM_r31_ctrl     <= bus.i_EX_r31_ctrl    & ~i_flush;
                bus.o_MEM_hlt          <= bus.i_EX_hlt         & ~i_flush;
                bus.o_MEM_branch_addr  <= bus.i_EX_branch_addr;
                bus.o_MEM_alu_result   <= bus.i_EX_alu_result;
                bus.o_MEM_write_data   <= bus.i_EX_write_data;
                bus.o_MEM_selected_reg <= bus.i_EX_selected_reg;
                bus.o_MEM_pc           <= bus.i_EX_pc;
                if (bus.i_EX_hlt && !i_flush) begin
                    o_halted <= 1'b1;
                end
            end
        end
    end

endmodule
